// File: rtl/enc_pkg.sv
// Shared definitions for the 4-to-2 event encoder.
//   NUM_IN  : number of event lines
//   CODE_W  : width of the encoded index
//   state_t : offer FSM states (IDLE = nothing offered, OFFER = D/valid presented)
package enc_pkg;

    localparam int NUM_IN = 4;
    localparam int CODE_W = 2;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

endpackage

// File: rtl/rr_pick4.sv
// Combinational picker over the pending vector.
//   req  : pending request bits
//   last : index accepted most recently
//   mode : 1 = rotating priority starting at last+1, 0 = lowest index wins
//   idx  : chosen index (0 when nothing is requested)
//   any  : at least one request present
module rr_pick4
    import enc_pkg::*;
(
    input  logic [NUM_IN-1:0] req,
    input  logic [CODE_W-1:0] last,
    input  logic              mode,
    output logic [CODE_W-1:0] idx,
    output logic              any
);

    logic [CODE_W-1:0] start;
    logic [CODE_W-1:0] cand;
    logic              found;

    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        start = mode ? (last + CODE_W'(1)) : '0;
        cand  = '0;
        idx   = '0;
        found = 1'b0;
        any   = |req;
        // The CODE_W-bit add wraps naturally, giving the mod-4 circular search.
        for (int i = 0; i < NUM_IN; i++) begin
            cand = start + CODE_W'(i);
            if (!found && req[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/event_encoder4x2.sv
// Event encoder: captures pulses on I into a pending set and offers them one
// at a time as a 2-bit code with a valid/ready handshake.
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset
//   I        : event lines, I[k] requests code k
//   Enable   : capture enable for I
//   D        : offered code (registered)
//   valid    : D holds an offered code (registered)
//   ready    : consumer accepts D when valid && ready
//   pending  : captured, not-yet-accepted events (registered)
//   overflow : sticky lost-event flag (registered)
//   clr_ovf  : clears overflow (a simultaneous loss wins)
module event_encoder4x2
    import enc_pkg::*;
#(
    parameter int ROUND_ROBIN = 1
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_IN-1:0] I,
    input  logic              Enable,
    output logic [CODE_W-1:0] D,
    output logic              valid,
    input  logic              ready,
    output logic [NUM_IN-1:0] pending,
    output logic              overflow,
    input  logic              clr_ovf
);

    state_t            state;
    logic [CODE_W-1:0] last;
    logic [NUM_IN-1:0] set_vec;
    logic [NUM_IN-1:0] clr_vec;
    logic              accept;
    logic [CODE_W-1:0] pick_idx;
    logic              pick_any;

    always_comb begin
        set_vec = I & {NUM_IN{Enable}};
        accept  = (state == OFFER) && ready;
        clr_vec = accept ? (NUM_IN'(1) << D) : '0;
    end

    rr_pick4 u_pick (
        .req  (pending),
        .last (last),
        .mode (ROUND_ROBIN != 0),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            valid    <= 1'b0;
            D        <= '0;
            pending  <= '0;
            overflow <= 1'b0;
            // Start from the top index so index 0 has first rotating priority.
            last     <= CODE_W'(NUM_IN - 1);
        end else begin
            // New events win over the clear of the code being accepted, which
            // re-arms that line rather than losing the event.
            pending <= set_vec | (pending & ~clr_vec);

            // An event is lost only if its line is already pending and is not
            // being freed on this same edge.
            if (|(set_vec & pending & ~clr_vec))
                overflow <= 1'b1;
            else if (clr_ovf)
                overflow <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (pick_any) begin
                        state <= OFFER;
                        valid <= 1'b1;
                        D     <= pick_idx;
                    end
                end
                OFFER: begin
                    // Accept always returns to IDLE, giving one bubble cycle
                    // in which the picker sees the updated pending and last.
                    if (ready) begin
                        state <= IDLE;
                        valid <= 1'b0;
                        last  <= D;
                    end
                end
                default: begin
                    state <= IDLE;
                    valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/event_encoder4x2.md
EVENT_ENCODER4X2 -- requirements
Module: event_encoder4x2

Interface
REQ-001 SHALL have parameter ROUND_ROBIN, default 1, meaning 1 = rotating priority and 0 = fixed priority with lowest index winning.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port I, input, 4 bits: event lines; I[k] high at a clk edge requests code k.
REQ-005 SHALL have port Enable, input, 1 bit: event capture enable; while low, I is ignored.
REQ-006 SHALL have port D, output, 2 bits: encoded index of the offered event; bit mapping is the inverse of the team's 2x4 decoder (D=k corresponds to line k).
REQ-007 SHALL have port valid, output, 1 bit: D holds an offered event.
REQ-008 SHALL have port ready, input, 1 bit: consumer accepts D when valid&&ready at an edge.
REQ-009 SHALL have port pending, output, 4 bits: captured, not-yet-accepted events.
REQ-010 SHALL have port overflow, output, 1 bit: sticky flag, set when an event is lost.
REQ-011 SHALL have port clr_ovf, input, 1 bit: clears overflow.
REQ-012 SHALL register all outputs; no output is combinationally dependent on any input.

Function
REQ-013 Capture rule: at each edge, pending[k] SHALL be set if I[k]&&Enable, else cleared if k is being accepted, else held; set wins over clear.
REQ-014 The FSM SHALL have two states. IDLE: valid=0. OFFER: valid=1, D stable.
REQ-015 IDLE->OFFER SHALL occur at the first edge where pending!=0; D is loaded at that same edge with the picked index.
REQ-016 In OFFER with ready=0, D and valid SHALL hold unchanged regardless of new events.
REQ-017 In OFFER with ready=1, the FSM SHALL go to IDLE, clear pending[D] (subject to REQ-013), and record last=D.
REQ-018 Throughput SHALL be at most one accepted code per 2 cycles, with one mandatory IDLE bubble after each accept.
REQ-019 Latency: an event sampled at edge t SHALL appear in pending after t and SHALL have valid asserted after edge t+1 at the earliest.
REQ-020 With ROUND_ROBIN=1, the pick SHALL be the first set pending bit searching from (last+1) mod 4 upward with wrap-around.
REQ-021 With ROUND_ROBIN=0, the pick SHALL be the lowest set pending index.
REQ-022 overflow SHALL be set when I[k]&&Enable while pending[k]=1 and k is not being accepted that edge.
REQ-023 overflow set SHALL win over a simultaneous clr_ovf.
REQ-024 An event on I[D] at the edge D is accepted SHALL re-arm pending[D] without setting overflow.
REQ-025 While Enable=0, pending SHALL only clear; offering and acceptance SHALL continue normally.

Reset
REQ-026 While rst=1 at an edge: pending=0, valid=0, D=0, overflow=0, last=3 (so index 0 has first priority), state=IDLE.
REQ-027 Reset SHALL override every other input, including a handshake or event in the same cycle.
REQ-028 Reset asserted mid-OFFER SHALL drop valid after that edge and discard the offered code.

Structure
REQ-029 A shared package enc_pkg SHALL hold the constants NUM_IN=4 and CODE_W=2 and the FSM state enumeration (IDLE, OFFER).
REQ-030 The pick logic SHALL be one combinational sub-module rr_pick4, with inputs req[3:0], last[1:0] and mode, and outputs idx[1:0] and any.
REQ-031 The total RTL SHALL be 120-400 lines.

Verification
REQ-032 Reset then I=0100 pulse with ready=1: pending=0100 after 1 edge; valid=1 with D=2 after 2 edges; pending=0 after the accept.
REQ-033 I=1111 pulse, ROUND_ROBIN=1, ready=1: accepted codes SHALL be 0,1,2,3, each separated by one IDLE cycle.
REQ-034 Same stimulus as REQ-033 with ROUND_ROBIN=0: accepted codes SHALL be 0,1,2,3; then re-inject I=0011 after accepting 0 -> next code 0, not 1.
REQ-035 Hold ready=0 with D=1 offered and pulse I=0010: overflow=1; D stays 1; pulse clr_ovf with no event -> overflow=0.
REQ-036 Accept D=3 while I=1000 in the same cycle: pending[3] stays 1, overflow stays 0, and D=3 is re-offered.
REQ-037 Assert rst during OFFER with pending=1010: all outputs are 0 after the edge; Enable=0 with I=1111 then leaves pending at 0.
